// File: rtl/lzoc_pipe.sv
// lzoc_pipe: pipelined leading-zero / leading-one counter with valid/ready
// handshake and a sideband tag. Mode 1 inverts the word and then counts
// leading zeros. Widths that are not a power of two are padded at the LSB end
// with ones, so the count stays exact. The register stages sit on the tree
// levels ceil(i*C_S/C_PIPE); with C_PIPE=0 the whole path is combinational.
// Optional feature macro: LZOC_PIPE_FLUSH_EN adds a synchronous 'flush' input
// that empties the pipe and keeps the datapath registers.
module lzoc_pipe #(
  parameter int C_N    = 64,
  parameter int C_S    = $clog2(C_N),
  parameter int C_PIPE = 2,
  parameter int C_TAG  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [C_N-1:0]   in_data,
  input  logic             in_mode,
  input  logic [C_TAG-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [C_S-1:0]   out_cnt,
  output logic             out_none,
  output logic [C_TAG-1:0] out_tag
`ifdef LZOC_PIPE_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  localparam int W   = 1 << C_S;
  localparam int PAD = W - C_N;

  // Returns the pipeline stage whose register sits on tree level k (0 = none).
  function automatic int unsigned stage_of(input int unsigned k);
    int unsigned s;
    s = 0;
    for (int unsigned i = 1; i <= C_PIPE; i++) begin
      if ((i * C_S + C_PIPE - 1) / C_PIPE == k) s = i;
    end
    return s;
  endfunction

  logic clr;
`ifdef LZOC_PIPE_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  logic [C_N-1:0] x;
  logic [W-1:0]   nx_ext;
  logic [W-1:0]   x_pad;
  logic           none_in;

  // After the optional inversion the searched bit is always 0. Pad bits are 1,
  // so a pad bit ends the scan exactly at the C_N boundary.
  assign x       = in_mode ? ~in_data : in_data;
  assign nx_ext  = W'(~x);
  assign x_pad   = ~(nx_ext << PAD);
  // 'none' must ignore the pad bits, so it comes from the original bits only.
  assign none_in = ~|x;

  // Stage 0 is the input port; stage C_PIPE drives the outputs.
  logic [C_PIPE:0]   vld_v;
  logic [C_PIPE:0]   none_v;
  logic [C_TAG-1:0]  tag_a [C_PIPE+1];
  logic [C_PIPE+1:1] rdy_v;

  assign vld_v[0]  = in_valid & ~clr;
  assign none_v[0] = none_in;
  assign tag_a[0]  = in_tag;
  assign in_ready  = rdy_v[1] & ~clr;

  // A stage can load when it is empty or everything downstream of it can move.
  always_comb begin
    rdy_v[C_PIPE+1] = out_ready;
    for (int unsigned i = C_PIPE; i >= 1; i--) begin
      rdy_v[i] = ~vld_v[i] | rdy_v[i+1];
    end
  end

  for (genvar i = 1; i <= C_PIPE; i++) begin : g_st
    logic             vld_q;
    logic             none_q;
    logic [C_TAG-1:0] tag_q;

    // Per-stage valid bit plus the sideband carried with the word.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q  <= 1'b0;
        none_q <= 1'b0;
        tag_q  <= '0;
      end else begin
        if (clr)           vld_q <= 1'b0;
        else if (rdy_v[i]) vld_q <= vld_v[i-1];
        if (rdy_v[i]) begin
          none_q <= none_v[i-1];
          tag_q  <= tag_a[i-1];
        end
      end
    end

    assign vld_v[i]  = vld_q;
    assign none_v[i] = none_q;
    assign tag_a[i]  = tag_q;
  end

  // Tree level k holds W>>k nodes, listed MSB side first. Each node has a
  // found flag and the zero count within its span.
  for (genvar k = 0; k <= C_S; k++) begin : g_lv
    localparam int          NN  = W >> k;
    localparam int unsigned STG = stage_of(k);
    logic [NN-1:0]  v;
    logic [C_S-1:0] c [NN];

    if (k == 0) begin : g_leaf
      // Each leaf is one bit of the padded word.
      always_comb begin
        for (int unsigned j = 0; j < NN; j++) begin
          v[j] = x_pad[W-1-j];
          c[j] = '0;
        end
      end
    end else begin : g_node
      logic [NN-1:0]  nv;
      logic [C_S-1:0] nc [NN];

      // Merge cell: take the left count if the left half found a 1, else
      // half the span plus the right count.
      always_comb begin
        for (int unsigned j = 0; j < NN; j++) begin
          nv[j] = g_lv[k-1].v[2*j] | g_lv[k-1].v[2*j+1];
          nc[j] = g_lv[k-1].v[2*j] ? g_lv[k-1].c[2*j]
                                   : (g_lv[k-1].c[2*j+1] | C_S'(1 << (k-1)));
        end
      end

      if (STG == 0) begin : g_comb
        assign v = nv;
        assign c = nc;
      end else begin : g_reg
        // Level register, advanced together with its stage valid.
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            v <= '0;
            c <= '{default: '0};
          end else if (rdy_v[STG]) begin
            v <= nv;
            c <= nc;
          end
        end
      end
    end
  end

  assign out_valid = vld_v[C_PIPE];
  assign out_tag   = tag_a[C_PIPE];
  assign out_none  = none_v[C_PIPE];
  // The root flag also gates the count, which keeps out_cnt at 0 after reset.
  assign out_cnt   = (g_lv[C_S].v[0] & ~out_none) ? g_lv[C_S].c[0] : '0;

endmodule

// File: tb/tb_lzoc_pipe.sv
// tb_lzoc_pipe: directed table vectors for C_N=16 and C_N=12 (C_PIPE=2),
// back-pressure, reset/flush with words in flight, and a short random stream
// checked against a bit-scan reference model.
module tb_lzoc_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_iv, a_ir, a_mode, a_ov, a_or, a_none;
  logic [15:0] a_data;
  logic [7:0]  a_tag, a_otag;
  logic [3:0]  a_cnt;
  logic        b_iv, b_ir, b_mode, b_ov, b_or, b_none;
  logic [11:0] b_data;
  logic [7:0]  b_tag, b_otag;
  logic [3:0]  b_cnt;
`ifdef LZOC_PIPE_FLUSH_EN
  logic        flush;
`endif

  lzoc_pipe #(.C_N(16), .C_S(4), .C_PIPE(2), .C_TAG(8)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_data),
    .in_mode(a_mode), .in_tag(a_tag), .out_valid(a_ov), .out_ready(a_or),
    .out_cnt(a_cnt), .out_none(a_none), .out_tag(a_otag)
`ifdef LZOC_PIPE_FLUSH_EN
    , .flush(flush)
`endif
  );

  lzoc_pipe #(.C_N(12), .C_S(4), .C_PIPE(2), .C_TAG(8)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_data),
    .in_mode(b_mode), .in_tag(b_tag), .out_valid(b_ov), .out_ready(b_or),
    .out_cnt(b_cnt), .out_none(b_none), .out_tag(b_otag)
`ifdef LZOC_PIPE_FLUSH_EN
    , .flush(flush)
`endif
  );

  typedef struct {
    logic [15:0] data;
    logic        mode;
    logic [7:0]  tag;
    logic [3:0]  cnt;
    logic        none;
  } vec_t;

  typedef struct {
    logic [3:0] cnt;
    logic       none;
    logic [7:0] tag;
  } res_t;

  int   nvec  = 0;
  int   nmiss = 0;
  vec_t va [14];
  vec_t vb [8];
  vec_t bp [4];
  res_t q  [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmiss++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference: scan from the MSB for the first bit different from the mode.
  function automatic logic [4:0] ref_lz(input logic [15:0] d, input logic m, input int unsigned n);
    int unsigned c;
    logic        hit;
    c   = 0;
    hit = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      if (!hit) begin
        if (d[n-1-i] != m) hit = 1'b1;
        else c++;
      end
    end
    return hit ? {1'b0, 4'(c)} : {1'b1, 4'd0};
  endfunction

  task automatic run_a(input vec_t v, input int unsigned idx);
    @(negedge clk);
    a_iv = 1'b1; a_data = v.data; a_mode = v.mode; a_tag = v.tag; a_or = 1'b1;
    #1 chk($sformatf("a%0d_in_ready", idx), 32'(a_ir), 32'd1);
    @(negedge clk);
    a_iv = 1'b0; a_data = '0;
    chk($sformatf("a%0d_early", idx), 32'(a_ov), 32'd0);
    @(negedge clk);
    chk($sformatf("a%0d_valid", idx), 32'(a_ov), 32'd1);
    chk($sformatf("a%0d_res", idx), 32'({a_cnt, a_none, a_otag}), 32'({v.cnt, v.none, v.tag}));
  endtask

  task automatic run_b(input vec_t v, input int unsigned idx);
    @(negedge clk);
    b_iv = 1'b1; b_data = v.data[11:0]; b_mode = v.mode; b_tag = v.tag; b_or = 1'b1;
    #1 chk($sformatf("b%0d_in_ready", idx), 32'(b_ir), 32'd1);
    @(negedge clk);
    b_iv = 1'b0; b_data = '0;
    chk($sformatf("b%0d_early", idx), 32'(b_ov), 32'd0);
    @(negedge clk);
    chk($sformatf("b%0d_valid", idx), 32'(b_ov), 32'd1);
    chk($sformatf("b%0d_res", idx), 32'({b_cnt, b_none, b_otag}), 32'({v.cnt, v.none, v.tag}));
  endtask

  initial begin
    int unsigned acc;
    int unsigned got;
    int unsigned seen;
    logic        take;
    logic [4:0]  r;
    res_t        e;

    va[0]  = '{16'h0010, 1'b0, 8'hA5, 4'd11, 1'b0};
    va[1]  = '{16'hFFF0, 1'b1, 8'h01, 4'd12, 1'b0};
    va[2]  = '{16'hFFFF, 1'b1, 8'h02, 4'd0,  1'b1};
    va[3]  = '{16'h0000, 1'b0, 8'h03, 4'd0,  1'b1};
    va[4]  = '{16'h8000, 1'b0, 8'h04, 4'd0,  1'b0};
    va[5]  = '{16'h0001, 1'b0, 8'h05, 4'd15, 1'b0};
    va[6]  = '{16'h7FFF, 1'b1, 8'h06, 4'd0,  1'b0};
    va[7]  = '{16'hFFFE, 1'b1, 8'h07, 4'd15, 1'b0};
    va[8]  = '{16'h0000, 1'b1, 8'h08, 4'd0,  1'b0};
    va[9]  = '{16'hFFFF, 1'b0, 8'h09, 4'd0,  1'b0};
    va[10] = '{16'h00FF, 1'b0, 8'h0A, 4'd8,  1'b0};
    va[11] = '{16'hF0F0, 1'b1, 8'h0B, 4'd4,  1'b0};
    va[12] = '{16'h1234, 1'b0, 8'h0C, 4'd3,  1'b0};
    va[13] = '{16'hC000, 1'b1, 8'h0D, 4'd2,  1'b0};

    vb[0] = '{16'h0001, 1'b0, 8'h20, 4'd11, 1'b0};
    vb[1] = '{16'h0800, 1'b0, 8'h21, 4'd0,  1'b0};
    vb[2] = '{16'h0000, 1'b0, 8'h22, 4'd0,  1'b1};
    vb[3] = '{16'h0FFF, 1'b1, 8'h23, 4'd0,  1'b1};
    vb[4] = '{16'h07FF, 1'b1, 8'h24, 4'd0,  1'b0};
    vb[5] = '{16'h0FFE, 1'b1, 8'h25, 4'd11, 1'b0};
    vb[6] = '{16'h00F0, 1'b0, 8'h26, 4'd4,  1'b0};
    vb[7] = '{16'h0000, 1'b1, 8'h27, 4'd0,  1'b0};

    bp[0] = '{16'h0010, 1'b0, 8'h10, 4'd11, 1'b0};
    bp[1] = '{16'h0100, 1'b0, 8'h11, 4'd7,  1'b0};
    bp[2] = '{16'h1000, 1'b0, 8'h12, 4'd3,  1'b0};
    bp[3] = '{16'h0001, 1'b0, 8'h13, 4'd15, 1'b0};

    rst_n = 1'b0;
    a_iv = 1'b0; a_data = '0; a_mode = 1'b0; a_tag = '0; a_or = 1'b1;
    b_iv = 1'b0; b_data = '0; b_mode = 1'b0; b_tag = '0; b_or = 1'b1;
`ifdef LZOC_PIPE_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_a_out_valid", 32'(a_ov), 32'd0);
    chk("rst_a_in_ready", 32'(a_ir), 32'd1);
    chk("rst_a_outs", 32'({a_cnt, a_none, a_otag}), 32'd0);
    chk("rst_b_out_valid", 32'(b_ov), 32'd0);
    chk("rst_b_in_ready", 32'(b_ir), 32'd1);

    for (int unsigned i = 0; i < 14; i++) run_a(va[i], i);
    for (int unsigned i = 0; i < 8; i++)  run_b(vb[i], i);

    // Back-pressure: consumer stalled, four words offered back to back.
    acc = 0;
    for (int unsigned cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      a_or = 1'b0;
      a_iv = (acc < 4);
      a_data = bp[acc % 4].data; a_mode = bp[acc % 4].mode; a_tag = bp[acc % 4].tag;
      #1;
      if (a_ov) chk("bp_hold_tag", 32'({a_cnt, a_otag}), 32'({4'd11, 8'h10}));
      take = a_iv & a_ir;
      @(posedge clk);
      if (take) acc++;
    end
    chk("bp_accepted", acc, 32'd2);
    @(negedge clk);
    #1;
    chk("bp_in_ready_full", 32'(a_ir), 32'd0);
    chk("bp_out_valid_full", 32'(a_ov), 32'd1);
    got = 0;
    for (int unsigned cyc = 0; cyc < 20 && got < 4; cyc++) begin
      @(negedge clk);
      a_or = 1'b1;
      a_iv = (acc < 4);
      a_data = bp[acc % 4].data; a_mode = bp[acc % 4].mode; a_tag = bp[acc % 4].tag;
      #1;
      if (a_ov) begin
        chk($sformatf("bp_out%0d", got), 32'({a_cnt, a_none, a_otag}),
            32'({bp[got].cnt, bp[got].none, bp[got].tag}));
        got++;
      end
      take = a_iv & a_ir;
      @(posedge clk);
      if (take) acc++;
    end
    chk("bp_emitted", got, 32'd4);

    // Reset with two words in flight.
    @(negedge clk);
    a_iv = 1'b0; a_or = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      @(negedge clk);
      a_iv = 1'b1; a_data = va[i].data; a_mode = va[i].mode; a_tag = va[i].tag;
    end
    @(negedge clk);
    a_iv = 1'b0;
    chk("rstm_pre_valid", 32'(a_ov), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstm_out_valid", 32'(a_ov), 32'd0);
    chk("rstm_in_ready", 32'(a_ir), 32'd1);
    chk("rstm_outs", 32'({a_cnt, a_none, a_otag}), 32'd0);
    a_or = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (a_ov) seen++;
    end
    chk("rstm_discarded", seen, 32'd0);

`ifdef LZOC_PIPE_FLUSH_EN
    // Flush with two words in flight, and a third offered during the flush.
    a_or = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      @(negedge clk);
      a_iv = 1'b1; a_data = va[i].data; a_mode = va[i].mode; a_tag = va[i].tag;
    end
    @(negedge clk);
    a_data = va[4].data; a_tag = va[4].tag;
    flush = 1'b1;
    #1;
    chk("fl_in_ready", 32'(a_ir), 32'd0);
    @(negedge clk);
    flush = 1'b0; a_iv = 1'b0;
    #1;
    chk("fl_out_valid", 32'(a_ov), 32'd0);
    a_or = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (a_ov) seen++;
    end
    chk("fl_discarded", seen, 32'd0);
`endif

    // Random stream against the reference model and an in-order scoreboard.
    for (int unsigned cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      a_iv   = ($urandom_range(0, 3) != 0);
      a_or   = ($urandom_range(0, 3) != 0);
      a_mode = 1'($urandom_range(0, 1));
      a_data = 16'($urandom) >> $urandom_range(0, 16);
      if ($urandom_range(0, 1) != 0) a_data = ~a_data;
      a_tag  = 8'(cyc);
      #1;
      chk("rnd_in_ready", 32'(a_ir), 32'(!(q.size() == 2 && !a_or)));
      if (a_ov && a_or) begin
        if (q.size() == 0) begin
          chk("rnd_spurious", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("rnd_res", 32'({a_cnt, a_none, a_otag}), 32'({e.cnt, e.none, e.tag}));
        end
      end
      if (a_iv && a_ir) begin
        r = ref_lz(a_data, a_mode, 16);
        q.push_back('{r[3:0], r[4], a_tag});
      end
      @(posedge clk);
    end
    @(negedge clk);
    a_iv = 1'b0; a_or = 1'b1;
    for (int unsigned cyc = 0; cyc < 10 && q.size() != 0; cyc++) begin
      #1;
      if (a_ov) begin
        e = q.pop_front();
        chk("rnd_drain_res", 32'({a_cnt, a_none, a_otag}), 32'({e.cnt, e.none, e.tag}));
      end
      @(negedge clk);
    end
    chk("rnd_drain_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule
